// File: rtl/seq_array_mult.sv
// Sequential radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or signed per operation.
// Optional MAC mode (product accumulates onto the previous result) enabled by defining SEQ_MULT_ACC_EN.
//
// state | meaning
// IDLE  | ready for operands, in_ready high
// CALC  | one shift-add iteration per cycle, WIDTH cycles
// DONE  | product valid and held until out_ready
module seq_array_mult #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
`ifdef SEQ_MULT_ACC_EN
  input  logic               acc_en,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   sext_a, sext_b, mag_a, mag_b;
  logic [WIDTH:0]   mcand, mplier;
  logic [PW:0]      acc, acc_sum, acc_nxt;
  logic [PW-1:0]    res_mag, res;
  logic [CNT_W-1:0] cnt;
  logic             neg, neg_in, cnt_last, accept;
`ifdef SEQ_MULT_ACC_EN
  logic             acc_en_q;
`endif

  // One extra bit so that |-2^(WIDTH-1)| is representable.
  always_comb begin
    sext_a = {signed_mode & a[WIDTH-1], a};
    sext_b = {signed_mode & b[WIDTH-1], b};
    mag_a  = sext_a[WIDTH] ? -sext_a : sext_a;
    mag_b  = sext_b[WIDTH] ? -sext_b : sext_b;
    neg_in = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  always_comb begin
    acc_sum = acc;
    if (mplier[0]) acc_sum[PW:WIDTH] = acc[PW:WIDTH] + mcand;
    acc_nxt = acc_sum >> 1;
    res_mag = acc_nxt[PW-1:0];
    res     = neg ? -res_mag : res_mag;
  end

  assign cnt_last = (cnt == CNT_W'(WIDTH - 1));
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      product  <= '0;
`ifdef SEQ_MULT_ACC_EN
      acc_en_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand    <= mag_a;
            mplier   <= mag_b;
            neg      <= neg_in;
            acc      <= '0;
            cnt      <= '0;
`ifdef SEQ_MULT_ACC_EN
            acc_en_q <= acc_en;
`endif
          end
        end
        CALC: begin
          acc    <= acc_nxt;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          // Result (and optional accumulation) is folded into the last iteration.
          if (cnt_last) begin
`ifdef SEQ_MULT_ACC_EN
            product <= (acc_en_q ? product : '0) + res;
`else
            product <= res;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_array_mult.sv
// Directed self-checking bench for seq_array_mult at WIDTH=8.
// MAC scenario is included when SEQ_MULT_ACC_EN is defined.
module tb_seq_array_mult;

  logic        clk = 1'b0;
  logic        rst, in_valid, signed_mode, out_ready;
  logic [7:0]  a, b;
  logic        in_ready, out_valid, busy;
  logic [15:0] product;
`ifdef SEQ_MULT_ACC_EN
  logic        acc_en;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_array_mult #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .signed_mode(signed_mode),
`ifdef SEQ_MULT_ACC_EN
    .acc_en(acc_en),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product(product),
    .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept_op(input logic [7:0] av, input logic [7:0] bv, input logic sm);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    a = av; b = bv; signed_mode = sm; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic release_op;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; signed_mode = 1'b0;
`ifdef SEQ_MULT_ACC_EN
    acc_en = 1'b0;
`endif
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during: got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h want 0000", product); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_unsigned;
    int lat;
    accept_op(8'd13, 8'd11, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL u_in_ready_drop: got %b want 0", in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL u_busy: got %b want 1", busy); end
    wait_valid(lat);
    checks++; if (lat != 8) begin errors++; $display("FAIL u_latency: got %0d want 8", lat); end
    checks++; if (product !== 16'h008F) begin errors++; $display("FAIL u_13x11: got %h want 008f", product); end
    release_op();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL u_out_valid_fall: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL u_in_ready_back: got %b want 1", in_ready); end
    accept_op(8'd255, 8'd255, 1'b0);
    wait_valid(lat);
    checks++; if (product !== 16'hFE01) begin errors++; $display("FAIL u_255x255: got %h want fe01", product); end
    release_op();
  endtask

  task automatic test_signed;
    logic [7:0]  va [5] = '{8'h80, 8'hFD, 8'h00, 8'hFD, 8'hFF};
    logic [7:0]  vb [5] = '{8'h80, 8'h05, 8'hF9, 8'h05, 8'h7F};
    logic        vs [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] ve [5] = '{16'h4000, 16'hFFF1, 16'h0000, 16'h04F1, 16'hFF81};
    int lat;
    for (int i = 0; i < 5; i++) begin
      accept_op(va[i], vb[i], vs[i]);
      wait_valid(lat);
      checks++; if (lat != 8) begin errors++; $display("FAIL s_latency[%0d]: got %0d want 8", i, lat); end
      checks++; if (product !== ve[i]) begin errors++; $display("FAIL s_product[%0d]: got %h want %h", i, product, ve[i]); end
      release_op();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    accept_op(8'd6, 8'd7, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'(i + 1); b = 8'(i + 2);
      tick();
      checks++; if (product !== 16'h002A) begin errors++; $display("FAIL bp_stable[%0d]: got %h want 002a", i, product); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
    end
    in_valid = 1'b0;
    release_op();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_out_valid_fall: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_back: got %b want 1", in_ready); end
    checks++; if (product !== 16'h002A) begin errors++; $display("FAIL bp_product_held: got %h want 002a", product); end
  endtask

  task automatic test_reset_mid_calc;
    int lat;
    accept_op(8'd7, 8'd9, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL rm_product: got %h want 0000", product); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
    accept_op(8'd2, 8'd3, 1'b0);
    wait_valid(lat);
    checks++; if (lat != 8) begin errors++; $display("FAIL rm_latency: got %0d want 8", lat); end
    checks++; if (product !== 16'h0006) begin errors++; $display("FAIL rm_2x3: got %h want 0006", product); end
    release_op();
  endtask

  task automatic test_back_to_back;
    logic [7:0]  va [4] = '{8'd5, 8'hFE, 8'h7F, 8'd200};
    logic [7:0]  vb [4] = '{8'd6, 8'hFE, 8'h80, 8'd3};
    logic        vs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] ve [4] = '{16'h001E, 16'h0004, 16'hC080, 16'h0258};
    int idx = 0, ridx = 0, cyc = 0, last = 0;
    logic prev;
    a = va[0]; b = vb[0]; signed_mode = vs[0];
    in_valid = 1'b1; out_ready = 1'b1;
    while (ridx < 4 && cyc < 200) begin
      prev = in_ready;
      tick();
      cyc++;
      if (prev && idx < 4) begin
        if (idx > 0) begin
          checks++; if (cyc - last != 10) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d want 10", idx, cyc - last); end
        end
        last = cyc;
        idx++;
        if (idx < 4) begin a = va[idx]; b = vb[idx]; signed_mode = vs[idx]; end
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        checks++; if (product !== ve[ridx]) begin errors++; $display("FAIL b2b_product[%0d]: got %h want %h", ridx, product, ve[ridx]); end
        ridx++;
      end
    end
    checks++; if (ridx != 4) begin errors++; $display("FAIL b2b_results: got %0d want 4", ridx); end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
  endtask

`ifdef SEQ_MULT_ACC_EN
  task automatic test_mac;
    int lat;
    acc_en = 1'b0;
    accept_op(8'd10, 8'd10, 1'b0);
    wait_valid(lat);
    checks++; if (product !== 16'h0064) begin errors++; $display("FAIL mac_first: got %h want 0064", product); end
    release_op();
    acc_en = 1'b1;
    accept_op(8'd3, 8'd4, 1'b0);
    wait_valid(lat);
    checks++; if (lat != 8) begin errors++; $display("FAIL mac_latency: got %0d want 8", lat); end
    checks++; if (product !== 16'h0070) begin errors++; $display("FAIL mac_accum: got %h want 0070", product); end
    release_op();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    accept_op(8'd2, 8'd2, 1'b0);
    wait_valid(lat);
    checks++; if (product !== 16'h0004) begin errors++; $display("FAIL mac_after_rst: got %h want 0004", product); end
    release_op();
    acc_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
`ifdef SEQ_MULT_ACC_EN
    test_mac();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_array_mult.md
Name: seq_array_mult

Overview:
- Parametrised sequential radix-2 shift-add multiplier; next generation of the team's fixed 4x4 combinational array multiplier.
- Takes two WIDTH-bit operands, unsigned or two's-complement selectable per operation, and produces a 2*WIDTH-bit product.
- Valid/ready handshakes on input and output; sized so the top-level wrapper can drive it from ui_in/uio pins or a PCPI-style coprocessor front end.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..16.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high. Sampled on rising clk.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  1 = both operands two's-complement; 0 = unsigned.
- out_valid  output  1  product is valid and held.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  result register.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset values: in_ready=0 during the reset cycle, then 1 (IDLE). out_valid=0, product=0, busy=0. Internal counter, accumulator and operand registers are cleared.
- States are IDLE, CALC and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T0, latch |a| and |b| (magnitudes when signed_mode=1, raw values otherwise).
  - Latch the sign flag neg = signed_mode & (a[MSB]^b[MSB]).
  - Clear the partial-product accumulator and counter; go to CALC.
- CALC, one iteration per cycle for exactly WIDTH cycles:
  - If the multiplier LSB is 1, add the multiplicand into the upper half of the 2*WIDTH+1-bit accumulator.
  - Then shift the accumulator right by 1 and increment the counter.
  - On the final iteration (counter == WIDTH-1), load product with the result, two's-complement negated if neg. Go to DONE with out_valid=1.
- Latency: out_valid is high in the cycle following edge T0+WIDTH, i.e. WIDTH cycles after acceptance.
- DONE:
  - out_valid=1; product is held stable.
  - On out_valid&out_ready: clear out_valid and go to IDLE. in_ready returns to 1 in the next cycle; no same-cycle accept while in DONE.
- Width and arithmetic rules:
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and must be handled in WIDTH+1 bits or equivalent. Signed product range is [-(2^(2W-2)-2^(W-1)), 2^(2W-2)] and always fits 2*WIDTH bits.
  - Zero operand yields product 0 with neg ignored; the result is never -0, which is trivially 0 in two's complement.
- product retains its last value after the handshake until the next completion.
- in_valid, a, b and signed_mode are ignored outside IDLE.
- Reset mid-operation (CALC or DONE): the next cycle is IDLE with out_valid=0 and product=0. The aborted result is never presented.
- Simultaneous rst and any handshake: rst wins.

Optional Feature:
- Macro: SEQ_MULT_ACC_EN.
- When defined:
  - Adds input acc_en (1 bit), sampled with operands.
  - When acc_en=1 at acceptance, the delivered product = previous delivered product + new signed/unsigned product, modulo 2^(2*WIDTH) (MAC mode).
  - When acc_en=0, behaviour is plain multiply.
  - rst clears the accumulated value.
  - Latency is unchanged; the addition is folded into the final CALC cycle.
- When undefined: acc_en port is absent and behaviour is pure multiply.

Test Plan:
- WIDTH=8, unsigned, a=13, b=11 -> in_ready drops after accept; out_valid exactly 8 cycles later; product=16'h008F.
- Unsigned a=255, b=255 -> product=16'hFE01. Signed a=-128, b=-128 -> 16'h4000. Signed a=-3, b=5 -> 16'hFFF1. Signed a=0, b=-7 -> 16'h0000.
- Backpressure: out_ready held 0 for 5 cycles after out_valid -> product stable, in_ready=0, new in_valid pulses ignored. Then out_ready=1 -> out_valid falls next edge and in_ready=1 the cycle after.
- Reset mid-CALC: rst asserted 3 cycles after accepting 7*9 -> next cycle out_valid=0, product=0, in_ready=1. A following 2*3 returns 16'h0006 with normal latency.
- Back-to-back: out_ready tied 1, in_valid tied 1 with 4 operand pairs -> each result correct; accept-to-accept spacing is WIDTH+2 cycles.
- SEQ_MULT_ACC_EN defined: 10*10 with acc_en=0, then 3*4 with acc_en=1 -> products 16'h0064 then 16'h0070. Then rst followed by 2*2 with acc_en=1 -> 16'h0004.
